// File: rtl/c5_clkgen.sv
// Divided clock-enable / square-wave generator with a PLL-style lock timer
// and a sticky steady-lock flag. All outputs are registered.

module c5_clkgen_ch #(
   parameter int DIV_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             run_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o,
   output logic             clk_o
);
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             clk_q, clk_d;

   // Terminal count is div-1, so the counter never exceeds 2^DIV_W-2.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      clk_d  = clk_q;
      if (!run_i || div_i == '0) begin
         cnt_d = '0;
         clk_d = 1'b0;
      end else if (cnt_q == div_i - DIV_W'(1)) begin
         cnt_d  = '0;
         tick_d = 1'b1;
         clk_d  = ~clk_q;
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
         clk_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         clk_q  <= clk_d;
      end
   end

   assign tick_o = tick_q;
   assign clk_o  = clk_q;
endmodule

module c5_clkgen #(
   parameter int CHANNELS    = 4,
   parameter int DIV_W       = 8,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                      I_clk,
   input  logic                      I_rst,
   input  logic [CHANNELS*DIV_W-1:0] I_div,
   input  logic                      I_locked_stdy_rst,
   output logic [CHANNELS-1:0]       O_tick,
   output logic [CHANNELS-1:0]       O_clk,
   output logic                      O_locked,
   output logic                      O_locked_stdy
);
   localparam int LW = $clog2(LOCK_CYCLES + 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

   logic [CHANNELS*DIV_W-1:0] div_q;
   logic [LW-1:0]             lock_cnt_q, lock_cnt_d;
   logic                      locked_q, locked_d;
   logic                      lost_q, lost_d;
   logic                      stdy_q, stdy_d;
   logic                      change;
   logic                      run;

   assign change = (I_div != div_q);
   // Channels are cleared on the same edge that drops lock for a divisor change.
   assign run    = locked_q & ~change;

   always_comb begin
      lock_cnt_d = lock_cnt_q;
      locked_d   = locked_q;
      lost_d     = lost_q;
      if (change) begin
         locked_d   = 1'b0;
         lock_cnt_d = '0;
      end else if (!locked_q) begin
         if (lock_cnt_q == LOCK_LAST) locked_d = 1'b1;
         else                         lock_cnt_d = lock_cnt_q + LW'(1);
      end
      if (change && locked_q)     lost_d = 1'b1;
      else if (I_locked_stdy_rst) lost_d = 1'b0;
      stdy_d = locked_d & ~lost_d;
   end

   always_ff @(posedge I_clk) begin
      div_q <= I_div;
      if (I_rst) begin
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
         lost_q     <= 1'b0;
         stdy_q     <= 1'b0;
      end else begin
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
         lost_q     <= lost_d;
         stdy_q     <= stdy_d;
      end
   end

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      c5_clkgen_ch #(.DIV_W(DIV_W)) u_ch (
         .clk_i  (I_clk),
         .rst_i  (I_rst),
         .run_i  (run),
         .div_i  (div_q[n*DIV_W +: DIV_W]),
         .tick_o (O_tick[n]),
         .clk_o  (O_clk[n])
      );
   end

   assign O_locked      = locked_q;
   assign O_locked_stdy = stdy_q;
endmodule

// File: tb/tb_c5_clkgen.sv
// Scoreboard bench for c5_clkgen: an edge-count model predicts every output
// after each rising edge; scenario tasks add targeted checks on top.

module tb_c5_clkgen;
   localparam int CH = 4;
   localparam int DW = 8;
   localparam int L  = 16;
   localparam logic [31:0] DIV_A = 32'h0001_0304; // ch0=4 ch1=3 ch2=1 ch3=0
   localparam logic [31:0] DIV_B = 32'h0001_0305; // ch0=5
   localparam logic [31:0] DIV_C = 32'h0001_03FF; // ch0=255

   logic                clk = 1'b0;
   logic                I_rst = 1'b1;
   logic [CH*DW-1:0]    I_div = '0;
   logic                I_locked_stdy_rst = 1'b0;
   logic [CH-1:0]       O_tick, O_clk;
   logic                O_locked, O_locked_stdy;

   typedef struct {
      logic [CH-1:0] tick;
      logic [CH-1:0] clk;
      logic          locked;
      logic          stdy;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          k = 0;
   bit          lost_m = 1'b0;
   logic [31:0] prev_m = '0;
   int          edge_n = 0;

   c5_clkgen #(.CHANNELS(CH), .DIV_W(DW), .LOCK_CYCLES(L)) dut (
      .I_clk             (clk),
      .I_rst             (I_rst),
      .I_div             (I_div),
      .I_locked_stdy_rst (I_locked_stdy_rst),
      .O_tick            (O_tick),
      .O_clk             (O_clk),
      .O_locked          (O_locked),
      .O_locked_stdy     (O_locked_stdy)
   );

   always #5 clk = ~clk;

   // Drive one edge, predict its outputs from the edge count since the last
   // reset/restart, then pop and compare after the edge.
   task automatic step(input logic rst, input logic [31:0] div, input logic srst);
      exp_t e;
      int   d;
      @(negedge clk);
      I_rst = rst; I_div = div; I_locked_stdy_rst = srst;
      if (rst) begin
         k = 0; lost_m = 1'b0;
      end else if (div != prev_m) begin
         if (k >= L)    lost_m = 1'b1;
         else if (srst) lost_m = 1'b0;
         k = 0;
      end else begin
         if (srst) lost_m = 1'b0;
         k++;
      end
      prev_m   = div;
      e.locked = (k >= L);
      e.stdy   = e.locked && !lost_m;
      for (int c = 0; c < CH; c++) begin
         d = int'(prev_m[c*DW +: DW]);
         e.tick[c] = (d != 0) && (k > L) && ((k - L) % d == 0);
         e.clk[c]  = (d != 0) && (k >= L) && (((k - L) / d) % 2 == 1);
      end
      sb.push_back(e);
      @(posedge clk); #1;
      edge_n++;
      e = sb.pop_front();
      checks += 4;
      if (O_tick !== e.tick) begin
         errors++; $display("FAIL sb_tick edge %0d got %b exp %b", edge_n, O_tick, e.tick);
      end
      if (O_clk !== e.clk) begin
         errors++; $display("FAIL sb_clk edge %0d got %b exp %b", edge_n, O_clk, e.clk);
      end
      if (O_locked !== e.locked) begin
         errors++; $display("FAIL sb_locked edge %0d got %b exp %b", edge_n, O_locked, e.locked);
      end
      if (O_locked_stdy !== e.stdy) begin
         errors++; $display("FAIL sb_stdy edge %0d got %b exp %b", edge_n, O_locked_stdy, e.stdy);
      end
   endtask

   task automatic test_reset();
      step(1'b1, DIV_A, 1'b0);
      step(1'b1, DIV_A, 1'b0);
      checks++;
      if ({O_tick, O_clk, O_locked, O_locked_stdy} !== '0) begin
         errors++;
         $display("FAIL reset_state got %b exp 0", {O_tick, O_clk, O_locked, O_locked_stdy});
      end
   endtask

   task automatic test_basic();
      int rise = -1, first0 = -1, first1 = -1, ch3 = 0;
      for (int i = 1; i <= 40; i++) begin
         step(1'b0, DIV_A, 1'b0);
         if (O_locked && rise < 0) rise = i;
         if (O_tick[0] && first0 < 0) first0 = i;
         if (O_tick[1] && first1 < 0) first1 = i;
         if (O_tick[3] || O_clk[3]) ch3++;
      end
      checks += 4;
      if (rise != L) begin errors++; $display("FAIL lock_rise got %0d exp %0d", rise, L); end
      if (first0 != L + 4) begin errors++; $display("FAIL ch0_first got %0d exp %0d", first0, L + 4); end
      if (first1 != L + 3) begin errors++; $display("FAIL ch1_first got %0d exp %0d", first1, L + 3); end
      if (ch3 != 0) begin errors++; $display("FAIL ch3_off got %0d exp 0", ch3); end
   endtask

   task automatic test_relock();
      int first0 = -1;
      step(1'b0, DIV_B, 1'b0);
      checks++;
      if ({O_tick, O_clk, O_locked, O_locked_stdy} !== '0) begin
         errors++;
         $display("FAIL relock_drop got %b exp 0", {O_tick, O_clk, O_locked, O_locked_stdy});
      end
      for (int i = 1; i <= 30; i++) begin
         step(1'b0, DIV_B, 1'b0);
         if (O_tick[0] && first0 < 0) first0 = i;
      end
      checks += 2;
      if (first0 != L + 5) begin errors++; $display("FAIL relock_ch0_first got %0d exp %0d", first0, L + 5); end
      if (O_locked_stdy !== 1'b0) begin errors++; $display("FAIL relock_stdy got %b exp 0", O_locked_stdy); end
   endtask

   task automatic test_stdy_rst();
      step(1'b0, DIV_B, 1'b1);
      checks++;
      if (O_locked_stdy !== 1'b1) begin errors++; $display("FAIL stdy_set got %b exp 1", O_locked_stdy); end
      step(1'b0, DIV_B, 1'b0);
      step(1'b0, DIV_A, 1'b1);
      checks++;
      if (O_locked_stdy !== 1'b0) begin errors++; $display("FAIL stdy_race got %b exp 0", O_locked_stdy); end
      for (int i = 0; i < L + 2; i++) step(1'b0, DIV_A, 1'b0);
      checks++;
      if (O_locked !== 1'b1 || O_locked_stdy !== 1'b0) begin
         errors++; $display("FAIL stdy_after_race got %b%b exp 10", O_locked, O_locked_stdy);
      end
   endtask

   task automatic test_mid_reset();
      bit found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b0, DIV_A, 1'b0);
         if (O_clk[0]) found = 1'b1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL mid_reset_clkhi got 0 exp 1"); end
      step(1'b1, DIV_A, 1'b0);
      checks++;
      if ({O_tick, O_clk, O_locked, O_locked_stdy} !== '0) begin
         errors++;
         $display("FAIL mid_reset_clear got %b exp 0", {O_tick, O_clk, O_locked, O_locked_stdy});
      end
      for (int i = 0; i < L + 10; i++) step(1'b0, DIV_A, 1'b0);
   endtask

   task automatic test_d255();
      int last = -1, bad = 0, n = 0;
      step(1'b1, DIV_C, 1'b0);
      for (int i = 1; i <= L + 255 * 3 + 5; i++) begin
         step(1'b0, DIV_C, 1'b0);
         if (O_tick[0]) begin
            if (last >= 0 && i - last != 255) bad++;
            if (last < 0 && i != L + 255) bad++;
            last = i; n++;
         end
      end
      checks += 2;
      if (bad != 0) begin errors++; $display("FAIL d255_period got %0d bad intervals exp 0", bad); end
      if (n != 3) begin errors++; $display("FAIL d255_count got %0d exp 3", n); end
   endtask

   task automatic test_lock_change();
      step(1'b1, DIV_A, 1'b0);
      for (int i = 1; i < 8; i++) step(1'b0, DIV_A, 1'b0);
      step(1'b0, DIV_B, 1'b0);
      for (int i = 1; i < L; i++) step(1'b0, DIV_B, 1'b0);
      checks++;
      if (O_locked !== 1'b0) begin errors++; $display("FAIL chg_early got %b exp 0", O_locked); end
      step(1'b0, DIV_B, 1'b0);
      checks++;
      if (O_locked !== 1'b1 || O_locked_stdy !== 1'b1) begin
         errors++; $display("FAIL chg_lock got %b%b exp 11", O_locked, O_locked_stdy);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_relock();
      test_stdy_rst();
      test_mid_reset();
      test_d255();
      test_lock_change();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
